fb_burst_arb: RTL and testbench
===============================

FB_BURST_ARB -- requirements
Module: fb_burst_arb

Interface
REQ-001 SHALL have parameter WR_BURST_SIZE, default 8: beats per camera-to-memory write burst.
REQ-002 SHALL have parameter RD_BURST_SIZE, default 16: beats per memory-to-ADV read burst.
REQ-003 SHALL have parameter FRAME_WORDS, default 307200: memory words per frame.
REQ-004 SHALL have parameter ADDR_W, default 25: memory address width.
REQ-005 SHALL have port clk  in  1: single clock for the whole block.
REQ-006 SHALL have port reset  in  1: synchronous, active-low reset.
REQ-007 SHALL have port init_done  in  1: system initialisation complete.
REQ-008 SHALL have port wr_pend  in  1: camera FIFO holds at least WR_BURST_SIZE words.
REQ-009 SHALL have port rd_room  in  1: ADV FIFO has at least RD_BURST_SIZE words free.
REQ-010 SHALL have port rd_urgent  in  1: ADV FIFO is near empty; reads get priority.
REQ-011 SHALL have ports avl_ready and avl_rdata_valid  in  1 each: memory handshakes.
REQ-012 SHALL have ports avl_write_req, avl_read_req and avl_burstbegin  out  1 each: memory command strobes.
REQ-013 SHALL have port avl_size  out  5: burst length of the current command.
REQ-014 SHALL have port avl_addr  out  ADDR_W: word address of the current burst.
REQ-015 SHALL have ports rdreq_cam and wrreq_adv  out  1 each: camera FIFO pop and ADV FIFO push.
REQ-016 SHALL have ports wr_frame_done and rd_frame_done  out  1 each: one-cycle frame-wrap pulses.
REQ-017 SHALL have port busy  out  1: high in any state other than S_IDLE.

Function
REQ-018 SHALL implement the states S_IDLE, S_WR, S_RD_CMD and S_RD_DATA.
REQ-019 S_IDLE SHALL stay in S_IDLE while init_done=0.
REQ-020 S_IDLE arbitration SHALL use this order: (1) rd_urgent&rd_room -> S_RD_CMD; (2) wr_pend and rd_room both set -> the requester not granted last time (last_grant bit); (3) only one eligible -> that one; (4) none eligible -> stay.
REQ-021 The grant decision SHALL be registered, giving exactly one S_IDLE cycle between consecutive bursts.
REQ-022 S_WR SHALL assert avl_write_req every cycle, avl_size=WR_BURST_SIZE, and avl_burstbegin on the first beat only.
REQ-023 In S_WR, a beat SHALL be accepted when avl_ready=1; rdreq_cam SHALL equal avl_write_req&avl_ready combinationally.
REQ-024 S_WR SHALL return to S_IDLE after WR_BURST_SIZE accepted beats; a stalled beat (avl_ready=0) SHALL hold all outputs stable.
REQ-025 S_RD_CMD SHALL assert avl_read_req and avl_burstbegin, with avl_size=RD_BURST_SIZE, until avl_ready=1, then go to S_RD_DATA.
REQ-026 S_RD_DATA SHALL set wrreq_adv=avl_rdata_valid and count valid beats, returning to S_IDLE after RD_BURST_SIZE beats.
REQ-027 avl_rdata_valid outside S_RD_DATA SHALL be ignored and SHALL produce no wrreq_adv.
REQ-028 Write address wr_addr and read address rd_addr SHALL each advance by their burst size at burst end.
REQ-029 When an address reaches FRAME_WORDS it SHALL wrap to 0 and pulse the matching *_frame_done for one cycle.
REQ-030 avl_addr SHALL drive wr_addr in S_WR and rd_addr in S_RD_CMD; its value in other states is don't-care.
REQ-031 Beat counters SHALL be 5 bits wide; FRAME_WORDS SHALL be a multiple of both burst sizes; address arithmetic SHALL be ADDR_W wide and unsigned.
REQ-032 Both frame-done pulses SHALL never assert in the same cycle, since only one burst is active at a time.

Reset
REQ-033 reset=0 at a clock edge SHALL force S_IDLE and set wr_addr=0, rd_addr=0, both beat counters=0 and last_grant=read, even mid-burst.
REQ-034 During and after reset, all strobes, pulses and busy SHALL be 0, and avl_size SHALL be 0.

Configuration
REQ-035 With FB_BURST_ARB_STATS_EN defined, the block SHALL add outputs wr_burst_cnt[15:0], rd_burst_cnt[15:0] and stray_valid.
REQ-036 wr_burst_cnt and rd_burst_cnt SHALL count completed bursts, wrap at 16 bits, and clear on reset; stray_valid SHALL be sticky, set by REQ-027 events and cleared on reset.
REQ-037 Without FB_BURST_ARB_STATS_EN, these ports and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-038 The state encoding and burst-size defaults SHALL be placed in the shared package fb_pkg.
REQ-039 The block SHALL instantiate a single sub-module, fb_addr_gen (burst-step address counter with wrap and done pulse), once for writes and once for reads.

Verification
REQ-040 Test: init_done=0 with wr_pend=1 and rd_room=1 for 50 cycles -> no strobes asserted, busy=0.
REQ-041 Test: wr_pend=1 only, avl_ready=1 -> exactly 8 rdreq_cam pulses, avl_addr=0, next write burst at address 8.
REQ-042 Test: wr_pend and rd_room both held at 1 -> grants alternate R,W,R,W, with one idle cycle between bursts.
REQ-043 Test: rd_urgent=1 while the previous grant was a read and wr_pend=1 -> the next burst is still a read.
REQ-044 Test: drive writes to FRAME_WORDS-8, then complete one burst -> wr_frame_done pulses once, and the next write burst starts at address 0.
REQ-045 Test: reset=0 at beat 5 of a write burst with avl_ready toggling -> strobes low at the next edge, and the restart begins at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding, grant encoding and default sizes for the
// frame-buffer burst arbiter (fb_burst_arb) and its address generator.
package fb_pkg;

  localparam int WR_BURST_DEF    = 8;
  localparam int RD_BURST_DEF    = 16;
  localparam int FRAME_WORDS_DEF = 307200;
  localparam int ADDR_W_DEF      = 25;
  localparam int BEAT_W          = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR      = 2'd1,
    S_RD_CMD  = 2'd2,
    S_RD_DATA = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // Beat counter step: wraps to zero after the last beat of a burst.
  function automatic logic [BEAT_W-1:0] beat_next(input logic [BEAT_W-1:0] cnt,
                                                  input logic [BEAT_W-1:0] last);
    if (cnt == last) begin
      beat_next = {BEAT_W{1'b0}};
    end else begin
      beat_next = cnt + BEAT_W'(1);
    end
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: burst-step word address counter. Advances by STEP on each adv
// pulse, wraps to zero on reaching FRAME_WORDS and flags the wrap with a
// one-cycle frame_done pulse.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int STEP        = WR_BURST_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] FRAME_C = ADDR_W'(FRAME_WORDS);

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] sum_s;
  logic              done_r;

  assign sum_s = addr_r + STEP_C;

  // Address register with frame wrap and registered wrap pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_r <= {ADDR_W{1'b0}};
      done_r <= 1'b0;
    end else if (adv) begin
      if (sum_s >= FRAME_C) begin
        addr_r <= {ADDR_W{1'b0}};
        done_r <= 1'b1;
      end else begin
        addr_r <= sum_s;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign addr       = addr_r;
  assign frame_done = done_r;

endmodule

// File: rtl/fb_burst_arb.sv
// fb_burst_arb: arbitrates one memory port between camera write bursts and
// ADV read bursts. Reads that are urgent win outright; otherwise simultaneous
// requesters alternate. Optional statistics outputs are built when
// FB_BURST_ARB_STATS_EN is defined.
module fb_burst_arb
  import fb_pkg::*;
#(
  parameter int WR_BURST_SIZE = WR_BURST_DEF,
  parameter int RD_BURST_SIZE = RD_BURST_DEF,
  parameter int FRAME_WORDS   = FRAME_WORDS_DEF,
  parameter int ADDR_W        = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              wr_pend,
  input  logic              rd_room,
  input  logic              rd_urgent,
  input  logic              avl_ready,
  input  logic              avl_rdata_valid,
  output logic              avl_write_req,
  output logic              avl_read_req,
  output logic              avl_burstbegin,
  output logic [4:0]        avl_size,
  output logic [ADDR_W-1:0] avl_addr,
  output logic              rdreq_cam,
  output logic              wrreq_adv,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
`ifdef FB_BURST_ARB_STATS_EN
  output logic [15:0]       wr_burst_cnt,
  output logic [15:0]       rd_burst_cnt,
  output logic              stray_valid,
`endif
  output logic              busy
);

  localparam logic [BEAT_W-1:0] WR_LAST = BEAT_W'(WR_BURST_SIZE - 1);
  localparam logic [BEAT_W-1:0] RD_LAST = BEAT_W'(RD_BURST_SIZE - 1);
  localparam logic [4:0]        WR_SIZE = 5'(WR_BURST_SIZE);
  localparam logic [4:0]        RD_SIZE = 5'(RD_BURST_SIZE);

  arb_state_e        state_r, state_nxt_s;
  grant_e            last_grant_r;
  logic [BEAT_W-1:0] wr_beat_r, rd_beat_r;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic              wr_fd_s, rd_fd_s;
  logic              wr_end_s, rd_end_s;
  logic              wr_req_s, rd_req_s, bb_s, busy_s, cam_pop_s, adv_push_s;
  logic [4:0]        size_s;
  logic [ADDR_W-1:0] addr_s;

  fb_addr_gen #(.STEP(WR_BURST_SIZE), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) u_wr_addr (
    .clk(clk), .reset(reset), .adv(wr_end_s), .addr(wr_addr_s), .frame_done(wr_fd_s)
  );

  fb_addr_gen #(.STEP(RD_BURST_SIZE), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)) u_rd_addr (
    .clk(clk), .reset(reset), .adv(rd_end_s), .addr(rd_addr_s), .frame_done(rd_fd_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Remember who won the last grant and count accepted beats per burst
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_r <= GRANT_RD;
      wr_beat_r    <= {BEAT_W{1'b0}};
      rd_beat_r    <= {BEAT_W{1'b0}};
    end else begin
      if (state_r == S_IDLE && state_nxt_s == S_WR) begin
        last_grant_r <= GRANT_WR;
      end else if (state_r == S_IDLE && state_nxt_s == S_RD_CMD) begin
        last_grant_r <= GRANT_RD;
      end else begin
        last_grant_r <= last_grant_r;
      end
      if (state_r == S_WR && avl_ready) begin
        wr_beat_r <= beat_next(wr_beat_r, WR_LAST);
      end
      if (state_r == S_RD_DATA && avl_rdata_valid) begin
        rd_beat_r <= beat_next(rd_beat_r, RD_LAST);
      end
    end
  end

  // Next-state decode, arbitration and command strobes
  always_comb begin
    state_nxt_s = state_r;
    wr_end_s    = 1'b0;
    rd_end_s    = 1'b0;
    wr_req_s    = 1'b0;
    rd_req_s    = 1'b0;
    bb_s        = 1'b0;
    size_s      = 5'd0;
    addr_s      = {ADDR_W{1'b0}};
    cam_pop_s   = 1'b0;
    adv_push_s  = 1'b0;
    busy_s      = 1'b1;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
        if (!init_done) begin
          state_nxt_s = S_IDLE;
        end else if (rd_urgent && rd_room) begin
          state_nxt_s = S_RD_CMD;
        end else if (wr_pend && rd_room) begin
          state_nxt_s = (last_grant_r == GRANT_RD) ? S_WR : S_RD_CMD;
        end else if (wr_pend) begin
          state_nxt_s = S_WR;
        end else if (rd_room) begin
          state_nxt_s = S_RD_CMD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WR: begin
        wr_req_s  = 1'b1;
        bb_s      = (wr_beat_r == {BEAT_W{1'b0}});
        size_s    = WR_SIZE;
        addr_s    = wr_addr_s;
        cam_pop_s = avl_ready;
        if (avl_ready && wr_beat_r == WR_LAST) begin
          state_nxt_s = S_IDLE;
          wr_end_s    = 1'b1;
        end else begin
          state_nxt_s = S_WR;
        end
      end
      S_RD_CMD: begin
        rd_req_s = 1'b1;
        bb_s     = 1'b1;
        size_s   = RD_SIZE;
        addr_s   = rd_addr_s;
        if (avl_ready) begin
          state_nxt_s = S_RD_DATA;
        end else begin
          state_nxt_s = S_RD_CMD;
        end
      end
      S_RD_DATA: begin
        adv_push_s = avl_rdata_valid;
        if (avl_rdata_valid && rd_beat_r == RD_LAST) begin
          state_nxt_s = S_IDLE;
          rd_end_s    = 1'b1;
        end else begin
          state_nxt_s = S_RD_DATA;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Outputs are held quiet while reset is low, even before the edge lands
  assign avl_write_req  = reset & wr_req_s;
  assign avl_read_req   = reset & rd_req_s;
  assign avl_burstbegin = reset & bb_s;
  assign avl_size       = reset ? size_s : 5'd0;
  assign avl_addr       = addr_s;
  assign rdreq_cam      = reset & cam_pop_s;
  assign wrreq_adv      = reset & adv_push_s;
  assign wr_frame_done  = reset & wr_fd_s;
  assign rd_frame_done  = reset & rd_fd_s;
  assign busy           = reset & busy_s;

`ifdef FB_BURST_ARB_STATS_EN
  logic [15:0] wr_cnt_r, rd_cnt_r;
  logic        stray_r;

  // Completed-burst counters and sticky stray-valid flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt_r <= 16'd0;
      rd_cnt_r <= 16'd0;
      stray_r  <= 1'b0;
    end else begin
      if (wr_end_s) begin
        wr_cnt_r <= wr_cnt_r + 16'd1;
      end
      if (rd_end_s) begin
        rd_cnt_r <= rd_cnt_r + 16'd1;
      end
      if (avl_rdata_valid && state_r != S_RD_DATA) begin
        stray_r <= 1'b1;
      end
    end
  end

  assign wr_burst_cnt = wr_cnt_r;
  assign rd_burst_cnt = rd_cnt_r;
  assign stray_valid  = stray_r;
`endif

endmodule

// File: tb/tb_fb_burst_arb.sv
// tb_fb_burst_arb: directed bench for fb_burst_arb. Expected bursts (kind and
// address) are queued as stimulus is applied and popped when the DUT starts
// a burst; a small memory model answers reads.
module tb_fb_burst_arb;

  localparam int WR = 8;
  localparam int RD = 16;
  localparam int FW = 64;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset, init_done, wr_pend, rd_room, rd_urgent, avl_ready, avl_rdata_valid;
  logic          avl_write_req, avl_read_req, avl_burstbegin, rdreq_cam, wrreq_adv;
  logic          wr_frame_done, rd_frame_done, busy;
  logic [4:0]    avl_size;
  logic [AW-1:0] avl_addr;
`ifdef FB_BURST_ARB_STATS_EN
  logic [15:0]   wr_burst_cnt, rd_burst_cnt;
  logic          stray_valid;
`endif

  fb_burst_arb #(.WR_BURST_SIZE(WR), .RD_BURST_SIZE(RD), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .wr_pend(wr_pend), .rd_room(rd_room),
    .rd_urgent(rd_urgent), .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req), .avl_burstbegin(avl_burstbegin),
    .avl_size(avl_size), .avl_addr(avl_addr), .rdreq_cam(rdreq_cam), .wrreq_adv(wrreq_adv),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
`ifdef FB_BURST_ARB_STATS_EN
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt), .stray_valid(stray_valid),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         starts = 0;
  int         beat_cnt = 0;
  int         idle_run = 0;
  int         rd_left = 0;
  int         wr_fd_cnt = 0;
  int         rd_fd_cnt = 0;
  int         both_fd = 0;
  int         strobe_cnt = 0;
  bit         in_burst = 1'b0;
  bit         cur_is_wr = 1'b0;
  bit         aborted = 1'b0;
  bit         gap_check = 1'b0;
  bit         ready_toggle = 1'b0;
  bit         stray_force = 1'b0;
  logic       p_wreq = 1'b0, p_bb = 1'b0, p_ready = 1'b0, p_reset = 1'b0;
  logic [4:0] p_size = 5'd0;
  logic [AW-1:0] p_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    check("rdreq_cam_comb", 32'(rdreq_cam), 32'(avl_write_req & avl_ready));
    if (wr_frame_done) wr_fd_cnt++;
    if (rd_frame_done) rd_fd_cnt++;
    if (wr_frame_done && rd_frame_done) both_fd++;
    if (avl_write_req | avl_read_req | avl_burstbegin | rdreq_cam | wrreq_adv | busy) strobe_cnt++;
    if (p_wreq && !p_ready && reset && p_reset)
      check("stall_hold", {avl_write_req, avl_burstbegin, avl_size, avl_addr},
            {p_wreq, p_bb, p_size, p_addr});
    if (avl_burstbegin && !p_bb) begin
      if (gap_check) check("idle_gap", 32'(idle_run), 32'd1);
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("burst_kind", 32'(avl_write_req), 32'(e.is_wr));
        check("burst_addr", 32'(avl_addr), 32'(e.addr));
        check("burst_size", 32'(avl_size), e.is_wr ? 32'(WR) : 32'(RD));
      end
      starts++;
      in_burst  = 1'b1;
      cur_is_wr = avl_write_req;
      beat_cnt  = 0;
      aborted   = 1'b0;
    end
    if (rdreq_cam || wrreq_adv) beat_cnt++;
    if (in_burst && !busy) begin
      in_burst = 1'b0;
      if (!aborted)
        check(cur_is_wr ? "wr_beats" : "rd_beats", 32'(beat_cnt), cur_is_wr ? 32'(WR) : 32'(RD));
    end
    idle_run = busy ? 0 : idle_run + 1;
    if (wrreq_adv && rd_left > 0) rd_left--;
    if (avl_read_req && avl_ready) rd_left = RD;
    p_wreq  = avl_write_req;
    p_bb    = avl_burstbegin;
    p_size  = avl_size;
    p_addr  = avl_addr;
    p_ready = avl_ready;
    p_reset = reset;
  endtask

  // One clock: settle model-driven inputs, observe, then advance to the next negedge.
  task automatic step();
    avl_rdata_valid = (rd_left > 0) || stray_force;
    if (ready_toggle) avl_ready = ~avl_ready;
    #1;
    observe();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_starts(input int n);
    int target;
    target = starts + n;
    for (int i = 0; i < 400 && starts < target; i++) step();
    check("start_wait", 32'(starts >= target), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (in_burst || busy); i++) step();
    step();
    check("idle_wait", 32'(in_burst), 32'd0);
  endtask

  initial begin
    int wa;
    reset = 1'b0; init_done = 1'b1; wr_pend = 1'b1; rd_room = 1'b1; rd_urgent = 1'b1;
    avl_ready = 1'b1; avl_rdata_valid = 1'b0;
    @(negedge clk);
    step(); step();
    // Outputs quiet under reset even with every request raised
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({avl_write_req, avl_read_req, avl_burstbegin, rdreq_cam, wrreq_adv}), 32'd0);
    check("rst_size", 32'(avl_size), 32'd0);
    check("rst_pulses", 32'({wr_frame_done, rd_frame_done}), 32'd0);

    // init_done low blocks all grants
    reset = 1'b1; init_done = 1'b0; strobe_cnt = 0;
    for (int i = 0; i < 50; i++) step();
    check("no_init_activity", 32'(strobe_cnt), 32'd0);
    wr_pend = 1'b0; rd_room = 1'b0; rd_urgent = 1'b0; init_done = 1'b1;
    step();

    // Writes only: two bursts at 0 and 8
    sb.push_back('{1'b1, 25'd0});
    sb.push_back('{1'b1, 25'd8});
    wr_pend = 1'b1;
    wait_starts(2);
    wr_pend = 1'b0;
    wait_idle();

    // Both requesters held: alternation R,W,R,W with a single idle cycle between
    sb.push_back('{1'b0, 25'd0});
    sb.push_back('{1'b1, 25'd16});
    sb.push_back('{1'b0, 25'd16});
    sb.push_back('{1'b1, 25'd24});
    wr_pend = 1'b1; rd_room = 1'b1;
    wait_starts(1);
    gap_check = 1'b1;
    wait_starts(3);
    wr_pend = 1'b0; rd_room = 1'b0;
    wait_idle();
    gap_check = 1'b0;

    // Read alone, then urgent read wins again despite last grant being read
    sb.push_back('{1'b0, 25'd32});
    rd_room = 1'b1;
    wait_starts(1);
    rd_room = 1'b0;
    wait_idle();
    sb.push_back('{1'b0, 25'd48});
    wr_pend = 1'b1; rd_room = 1'b1; rd_urgent = 1'b1;
    wait_starts(1);
    wr_pend = 1'b0; rd_room = 1'b0; rd_urgent = 1'b0;
    wait_idle();
    check("rd_wrap_pulse", 32'(rd_fd_cnt), 32'd1);
    sb.push_back('{1'b0, 25'd0});
    rd_room = 1'b1;
    wait_starts(1);
    rd_room = 1'b0;
    wait_idle();

    // Writes up to the frame end with a stalling memory, then wrap to 0
    ready_toggle = 1'b1;
    sb.push_back('{1'b1, 25'd32});
    sb.push_back('{1'b1, 25'd40});
    sb.push_back('{1'b1, 25'd48});
    sb.push_back('{1'b1, 25'd56});
    sb.push_back('{1'b1, 25'd0});
    wr_pend = 1'b1;
    wait_starts(4);
    check("wr_no_early_wrap", 32'(wr_fd_cnt), 32'd0);
    wait_starts(1);
    check("wr_wrap_pulse", 32'(wr_fd_cnt), 32'd1);
    wr_pend = 1'b0;
    wait_idle();

    // Reset at beat 5 of a stalling write burst, then restart from address 0
    sb.push_back('{1'b1, 25'd8});
    wr_pend = 1'b1;
    wait_starts(1);
    for (int i = 0; i < 60 && beat_cnt < 5; i++) step();
    check("beat5_reached", 32'(beat_cnt >= 5), 32'd1);
    aborted = 1'b1;
    reset = 1'b0;
    step();
    check("mid_rst_strobes", 32'({avl_write_req, avl_burstbegin, rdreq_cam}), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    step();
    check("mid_rst_size", 32'(avl_size), 32'd0);
    reset = 1'b1; ready_toggle = 1'b0; avl_ready = 1'b1;
    sb.push_back('{1'b1, 25'd0});
    sb.push_back('{1'b0, 25'd0});
    rd_room = 1'b1;
    wait_starts(2);
    wr_pend = 1'b0; rd_room = 1'b0;
    wait_idle();

    // Read-data valid outside a read burst is ignored
    stray_force = 1'b1; wa = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wrreq_adv) wa++;
    end
    stray_force = 1'b0;
    check("stray_no_push", 32'(wa), 32'd0);
    check("stray_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("no_dual_pulse", 32'(both_fd), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
